// File: rtl/path_streamer.sv
// Captures a packed planner path on its done pulse, measures the length up to
// the first sentinel, then streams the nodes out over a valid/ready handshake.
module path_streamer #(
    parameter int MAX_LEN  = 10,
    parameter int NODE_W   = 5,
    parameter int SENTINEL = 31,
    parameter int IDX_W    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_path_done,
    input  logic [MAX_LEN*NODE_W-1:0] i_path_in,
    output logic                      o_busy,
    output logic                      o_node_valid,
    input  logic                      i_node_ready,
    output logic [NODE_W-1:0]         o_node_out,
    output logic [IDX_W-1:0]          o_node_idx,
    output logic                      o_node_last,
    output logic [IDX_W-1:0]          o_path_len,
    output logic                      o_stream_done,
    output logic                      o_overrun
);

    // state  | meaning
    // IDLE   | waiting for planner done, captures path
    // COUNT  | scanning one slot per cycle for the first sentinel
    // STREAM | presenting nodes on the valid/ready handshake
    // FIN    | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_STREAM, S_FIN} state_t;

    state_t                      r_state;
    logic [MAX_LEN*NODE_W-1:0]   r_path;
    logic [IDX_W-1:0]            r_scan;

    logic [NODE_W-1:0]           w_scan_slot;
    logic                        w_scan_end;
    logic [IDX_W-1:0]            w_next_idx;
    logic [NODE_W-1:0]           w_next_slot;
    logic [NODE_W-1:0]           w_first_slot;
    logic                        w_xfer;

    // Index MAX_LEN is a legal scan position (full path) so it must decode to 0.
    function automatic logic [NODE_W-1:0] slot_at(input logic [MAX_LEN*NODE_W-1:0] p,
                                                  input logic [IDX_W-1:0] idx);
        logic [NODE_W-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (idx == IDX_W'(k)) v = p[k*NODE_W +: NODE_W];
        end
        return v;
    endfunction

    assign w_scan_slot  = slot_at(r_path, r_scan);
    assign w_scan_end   = (r_scan == IDX_W'(MAX_LEN)) || (w_scan_slot == NODE_W'(SENTINEL));
    assign w_next_idx   = o_node_idx + IDX_W'(1);
    assign w_next_slot  = slot_at(r_path, w_next_idx);
    assign w_first_slot = r_path[NODE_W-1:0];
    assign w_xfer       = o_node_valid && i_node_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_path        <= '0;
            r_scan        <= '0;
            o_busy        <= 1'b0;
            o_node_valid  <= 1'b0;
            o_node_out    <= '0;
            o_node_idx    <= '0;
            o_node_last   <= 1'b0;
            o_path_len    <= '0;
            o_stream_done <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_path_done) begin
                        r_path    <= i_path_in;
                        o_overrun <= 1'b0;
                        r_scan    <= '0;
                        o_busy    <= 1'b1;
                        r_state   <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (i_path_done) o_overrun <= 1'b1;
                    if (w_scan_end) begin
                        o_path_len <= r_scan;
                        o_node_idx <= '0;
                        if (r_scan != '0) begin
                            o_node_valid <= 1'b1;
                            o_node_out   <= w_first_slot;
                            o_node_last  <= (r_scan == IDX_W'(1));
                            r_state      <= S_STREAM;
                        end else begin
                            o_stream_done <= 1'b1;
                            r_state       <= S_FIN;
                        end
                    end else begin
                        r_scan <= r_scan + IDX_W'(1);
                    end
                end
                S_STREAM: begin
                    if (i_path_done) o_overrun <= 1'b1;
                    if (w_xfer) begin
                        if (o_node_last) begin
                            o_node_valid  <= 1'b0;
                            o_node_out    <= '0;
                            o_node_last   <= 1'b0;
                            o_stream_done <= 1'b1;
                            r_state       <= S_FIN;
                        end else begin
                            o_node_idx  <= w_next_idx;
                            o_node_out  <= w_next_slot;
                            o_node_last <= (w_next_idx == o_path_len - IDX_W'(1));
                        end
                    end
                end
                S_FIN: begin
                    if (i_path_done) o_overrun <= 1'b1;
                    o_stream_done <= 1'b0;
                    o_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_streamer.sv
// Scoreboard bench for path_streamer: directed paths push expected nodes and
// completion records; a negedge monitor pops and compares on each handshake.
module tb_path_streamer;
    localparam int MAX_LEN = 10;
    localparam int NODE_W  = 5;
    localparam int IDX_W   = 4;
    localparam int PW      = MAX_LEN*NODE_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              path_done = 1'b0;
    logic [PW-1:0]     path_in = '0;
    logic              node_ready = 1'b0;
    logic              busy, node_valid, node_last, stream_done, overrun;
    logic [NODE_W-1:0] node_out;
    logic [IDX_W-1:0]  node_idx, path_len;

    path_streamer #(.MAX_LEN(MAX_LEN), .NODE_W(NODE_W), .SENTINEL(31), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_path_done(path_done), .i_path_in(path_in),
        .o_busy(busy), .o_node_valid(node_valid), .i_node_ready(node_ready),
        .o_node_out(node_out), .o_node_idx(node_idx), .o_node_last(node_last),
        .o_path_len(path_len), .o_stream_done(stream_done), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [NODE_W-1:0] node; logic [IDX_W-1:0] idx; logic last; } exp_t;
    typedef struct { logic [IDX_W-1:0] len; logic ovr; } done_t;
    exp_t  exp_q[$];
    done_t done_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [PW-1:0] pack_path(input int s [MAX_LEN]);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_LEN; i++) p[i*NODE_W +: NODE_W] = NODE_W'(s[i]);
        return p;
    endfunction

    // Monitor: handshake scoreboard, hold-stability and completion records
    logic              m_pvalid = 1'b0, m_pready = 1'b0, m_plast = 1'b0;
    logic [NODE_W-1:0] m_pnode = '0;
    logic [IDX_W-1:0]  m_pidx = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_pvalid && !m_pready) begin
                chk("hold_valid", node_valid, 1);
                chk("hold_node", node_out, m_pnode);
                chk("hold_idx", node_idx, m_pidx);
                chk("hold_last", node_last, m_plast);
            end
            if (!node_valid) chk("node_out_zero_when_invalid", node_out, 0);
            if (node_valid && node_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_node", node_out, 0);
                    if (node_out == 0) chk("unexpected_node_present", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("node_out", node_out, e.node);
                    chk("node_idx", node_idx, e.idx);
                    chk("node_last", node_last, e.last);
                end
            end
            if (stream_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_stream_done", stream_done, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_path_len", path_len, d.len);
                    chk("done_overrun", overrun, d.ovr);
                    chk("done_busy", busy, 1);
                end
            end
        end
        m_pvalid = node_valid;
        m_pready = node_ready;
        m_pnode  = node_out;
        m_pidx   = node_idx;
        m_plast  = node_last;
    end

    // Capture a path and check the COUNT duration and measured length.
    task automatic start(input logic [PW-1:0] p, input int len, input logic ovr_at_done);
        int n;
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.node = p[i*NODE_W +: NODE_W];
            e.idx  = IDX_W'(i);
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
        begin
            done_t d;
            d.len = IDX_W'(len);
            d.ovr = ovr_at_done;
            done_q.push_back(d);
        end
        path_in   = p;
        path_done = 1'b1;
        @(posedge clk); #1;
        path_done = 1'b0;
        chk("busy_after_capture", busy, 1);
        chk("overrun_cleared_on_capture", overrun, 0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(node_valid || stream_done) && n < 40);
        chk("count_cycles", n, len + 1);
        chk("path_len", path_len, len);
    endtask

    // Apply a repeating ready pattern until stream_done; optionally re-pulse path_done.
    task automatic stream(input logic [7:0] pat, input int plen, input int pulse_at,
                          input logic [PW-1:0] alt, input int exp_cycles);
        int k;
        k = 0;
        do begin
            node_ready = pat[k % plen];
            if (k == pulse_at) begin
                path_in   = alt;
                path_done = 1'b1;
            end else begin
                path_done = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end while (!stream_done && k < 60);
        path_done = 1'b0;
        chk("stream_done_seen", stream_done, 1);
        chk("stream_cycles", k, exp_cycles);
        @(posedge clk); #1;
        chk("stream_done_one_cycle", stream_done, 0);
        chk("busy_low_after_fin", busy, 0);
    endtask

    logic [PW-1:0] p_a, p_empty, p_full, p_b, p_alt, p_c;

    initial begin
        p_a     = pack_path('{0, 4, 11, 31, 31, 31, 31, 31, 31, 31});
        p_empty = pack_path('{31, 5, 6, 31, 31, 31, 31, 31, 31, 31});
        p_full  = pack_path('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        p_b     = pack_path('{3, 7, 31, 12, 31, 31, 31, 31, 31, 31});
        p_alt   = pack_path('{20, 21, 22, 31, 31, 31, 31, 31, 31, 31});
        p_c     = pack_path('{1, 2, 31, 31, 31, 31, 31, 31, 31, 31});

        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", node_valid, 0);
        chk("reset_node_out", node_out, 0);
        chk("reset_path_len", path_len, 0);
        chk("reset_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Three-node path, ready always high
        node_ready = 1'b1;
        start(p_a, 3, 1'b0);
        stream(8'b0000_0001, 1, -1, '0, 3);

        // Same path with ready toggling 1,0,0,1,0,1
        node_ready = 1'b0;
        start(p_a, 3, 1'b0);
        stream(8'b0010_1001, 6, -1, '0, 6);

        // Empty path: sentinel in slot 0
        node_ready = 1'b1;
        start(p_empty, 0, 1'b0);
        chk("empty_done_pulse", stream_done, 1);
        chk("empty_no_valid", node_valid, 0);
        @(posedge clk); #1;
        chk("empty_busy_low", busy, 0);
        chk("empty_done_low", stream_done, 0);

        // Full path, no sentinel
        start(p_full, 10, 1'b0);
        stream(8'b0000_0001, 1, -1, '0, 10);

        // Overrun: re-pulse path_done mid-stream with a different path
        start(p_b, 2, 1'b1);
        stream(8'b0000_0001, 2, 1, p_alt, 3);
        chk("overrun_sticky_idle", overrun, 1);
        start(p_c, 2, 1'b0);
        stream(8'b0000_0001, 1, -1, '0, 2);

        // Reset mid-stream after two transfers
        node_ready = 1'b1;
        start(p_a, 3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_idx", node_idx, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", node_valid, 0);
        chk("abort_node_out", node_out, 0);
        chk("abort_idx", node_idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", stream_done, 0);
        chk("abort_path_len", path_len, 0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_done_after_abort", stream_done, 0);
        start(p_a, 3, 1'b0);
        chk("fresh_first_idx", node_idx, 0);
        stream(8'b0000_0001, 1, -1, '0, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/path_streamer.md
Name: path_streamer

Overview:
Consumer at the output end of the path planner's result interface. On the planner's done pulse it captures the packed final_path bus and measures the path length. It then streams the nodes one per valid/ready handshake, start node first, to a downstream motion or display stage. It emits a completion pulse when the last node has been accepted.

Parameters:
MAX_LEN, 10, number of node slots in the packed path bus
NODE_W, 5, bits per node ID
SENTINEL, 31, slot value marking the end of the path (unused slot)
IDX_W, 4, width of index/length outputs; must satisfy 2^IDX_W > MAX_LEN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
path_done  in  1  planner done; sampled level, captured only in IDLE
path_in  in  MAX_LEN*NODE_W  packed path; slot i = bits [i*NODE_W +: NODE_W]; slot 0 = start node
busy  out  1  high in every state except IDLE
node_valid  out  1  node_out holds a valid node
node_ready  in  1  downstream accepts node this cycle
node_out  out  NODE_W  current node ID
node_idx  out  IDX_W  slot index of node_out
node_last  out  1  node_out is the final node of the path
path_len  out  IDX_W  measured path length; valid from STREAM entry until next capture
stream_done  out  1  one-cycle pulse after last node accepted, or after empty path measured
overrun  out  1  sticky: path_done seen while busy

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; capture register 0.
- States: IDLE, COUNT, STREAM, FIN.
- IDLE: if path_done=1 at a rising edge:
  - latch path_in into the capture register;
  - clear overrun;
  - set scan index i=0;
  - go to COUNT.
  - path_done held high for several cycles produces a single capture, because capture happens only in IDLE.
- COUNT: one slot examined per cycle.
  - If i==MAX_LEN, or slot[i]==SENTINEL: path_len<=i; node_idx<=0.
    - Go to STREAM if i>0, else FIN.
  - Otherwise i<=i+1.
  - COUNT lasts L+1 cycles for path length L (including L=MAX_LEN with no sentinel).
  - Slots after the first sentinel are ignored.
- STREAM:
  - node_valid=1; node_out=slot[node_idx]; node_last=(node_idx==path_len-1).
  - node_out, node_idx and node_last stay stable while node_valid=1 and node_ready=0.
  - Transfer on valid&ready at an edge. If not last: node_idx++. If last: node_valid<=0, go to FIN.
  - No combinational path from node_ready to node_valid.
- FIN: stream_done=1 for exactly one cycle; go to IDLE. busy is still 1 in FIN and drops in IDLE.
- Overrun: path_done=1 in any non-IDLE state sets overrun, and the new path is ignored. The current stream completes unaffected.
- path_in is read only at capture; later changes have no effect.
- Reset asserted mid-operation: immediate abort to IDLE, outputs cleared, no stream_done.
- node_out is 0 when node_valid=0.

Test Plan:
- Path slots {0,4,11,31,...}, path_done 1 cycle, node_ready=1 -> COUNT 4 cycles; path_len=3; node_out 0,4,11 on 3 consecutive cycles; node_last only with 11; stream_done 1 cycle after, then busy=0.
- Same path, node_ready toggling 1,0,0,1,0,1 -> each node held stable while ready=0; exactly 3 transfers in order 0,4,11; no duplicates or drops.
- Slot0=31 (empty path) -> path_len=0; node_valid never asserted; stream_done pulses 1 cycle after the single COUNT cycle.
- All 10 slots valid (0..9), no sentinel -> COUNT 11 cycles; path_len=10; node_last on node 9 (node_idx=9).
- path_done re-pulsed during STREAM with a different path -> overrun=1; original nodes stream unchanged; next IDLE capture clears overrun.
- reset=0 mid-STREAM after 2 transfers -> outputs 0 immediately, no stream_done; a fresh path_done afterwards streams correctly from node_idx 0.
